// File: rtl/das_beam_sum_pkg.sv
// rtl/das_beam_sum_pkg.sv - shared FSM states, delay sentinel and output width helper (package das_pkg)
package das_pkg;

   // S_MUL is only visited when DAS_APOD_EN is defined
   typedef enum logic [2:0] {
      S_IDLE,
      S_DLY_RD,
      S_DLY_WAIT,
      S_SMP_RD,
      S_MUL,
      S_ACC,
      S_EMIT,
      S_DONE
   } das_state_e;

   // all-ones delay entry marks a channel that contributes nothing; cast to ADDR_W at use
   localparam logic [63:0] DLY_INVALID = '1;

   // width that holds the sum of num_ch full-scale samples without overflow
   function automatic int sum_width(input int sample_w, input int num_ch);
      return sample_w + $clog2(num_ch);
   endfunction

endpackage

// File: rtl/das_beam_sum_if.sv
// rtl/das_beam_sum_if.sv - delay/sample RAM read ports and beam output stream of das_beam_sum
interface das_beam_sum_if #(
   parameter int SAMPLE_W = 32,
   parameter int ADDR_W   = 13,
   parameter int DLY_AW   = 13,
   parameter int SUM_W    = 35
);
   logic                       dly_rd_en;
   logic [DLY_AW-1:0]          dly_rd_addr;
   logic [ADDR_W-1:0]          dly_rd_data;
   logic                       smp_rd_en;
   logic [ADDR_W-1:0]          smp_rd_addr;
   logic signed [SAMPLE_W-1:0] smp_rd_data;
   logic                       out_valid;
   logic                       out_ready;
   logic signed [SUM_W-1:0]    out_data;
   logic [DLY_AW-1:0]          out_idx;

   modport master (
      output dly_rd_en, dly_rd_addr, smp_rd_en, smp_rd_addr, out_valid, out_data, out_idx,
      input  dly_rd_data, smp_rd_data, out_ready
   );

   modport slave (
      input  dly_rd_en, dly_rd_addr, smp_rd_en, smp_rd_addr, out_valid, out_data, out_idx,
      output dly_rd_data, smp_rd_data, out_ready
   );
endinterface

// File: rtl/das_beam_sum_mac.sv
// rtl/das_beam_sum_mac.sv - das_channel_mac: sign-extend, optional apodisation (DAS_APOD_EN), accumulate with clear
module das_channel_mac
   import das_pkg::*;
#(
   parameter int SAMPLE_W = 32,
   parameter int SUM_W    = sum_width(32, 8)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_clear,
   input  logic                       i_acc_en,
   input  logic                       i_use,
   input  logic signed [SAMPLE_W-1:0] i_sample,
`ifdef DAS_APOD_EN
   input  logic                       i_mul_en,
   input  logic signed [15:0]         i_weight,
`endif
   output logic signed [SUM_W-1:0]    o_acc
);
   logic signed [SUM_W-1:0] r_acc;
   logic signed [SUM_W-1:0] w_term;

`ifdef DAS_APOD_EN
   logic signed [SAMPLE_W+15:0] w_prod;
   logic signed [SUM_W-1:0]     r_term;

   assign w_prod = i_sample * i_weight;

   // MUL stage: Q1.15 weighting, arithmetic shift keeps the sign of the product
   always_ff @(posedge clk) begin
      if (reset)         r_term <= '0;
      else if (i_mul_en) r_term <= i_use ? SUM_W'(w_prod >>> 15) : '0;
   end

   assign w_term = r_term;
`else
   assign w_term = i_use ? SUM_W'(i_sample) : '0;
`endif

   // running beam sum, cleared before the first channel of every output index
   always_ff @(posedge clk) begin
      if (reset)         r_acc <= '0;
      else if (i_clear)  r_acc <= '0;
      else if (i_acc_en) r_acc <= r_acc + w_term;
   end

   assign o_acc = r_acc;
endmodule

// File: rtl/das_beam_sum.sv
// rtl/das_beam_sum.sv - delay-and-sum beam engine top; DAS_APOD_EN enables per-channel apodisation weights
module das_beam_sum
   import das_pkg::*;
#(
   parameter int NUM_CH   = 8,
   parameter int SAMPLE_W = 32,
   parameter int NUM_OUT  = 768,
   parameter int ADDR_W   = 13,
   parameter int DLY_AW   = 13,
   parameter int SUM_W    = sum_width(SAMPLE_W, NUM_CH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   input  logic [NUM_CH*16-1:0] apod_w,
   das_beam_sum_if.master       bus
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   das_state_e              r_state, w_next;
   logic [CH_W-1:0]         r_ch;
   logic [DLY_AW-1:0]       r_k;
   logic [ADDR_W-1:0]       r_entry;
   logic [DLY_AW-1:0]       r_dly_addr_q;
   logic [ADDR_W-1:0]       r_smp_addr_q;
   logic                    w_last_ch, w_last_k, w_entry_ok, w_accept, w_clear;
   logic                    w_dly_en, w_smp_en;
   logic [DLY_AW-1:0]       w_dly_addr;
   logic signed [SUM_W-1:0] w_acc;

   assign w_last_ch  = (r_ch == CH_W'(NUM_CH - 1));
   assign w_last_k   = (r_k == DLY_AW'(NUM_OUT - 1));
   assign w_entry_ok = (r_entry != ADDR_W'(DLY_INVALID));
   assign w_accept   = (r_state == S_EMIT) && bus.out_ready;
   assign w_clear    = ((r_state == S_IDLE) && start) || w_accept;
   assign w_dly_addr = DLY_AW'(r_ch) * DLY_AW'(NUM_OUT) + r_k;
   assign w_dly_en   = (r_state == S_DLY_RD);
   assign w_smp_en   = (r_state == S_SMP_RD) && w_entry_ok;

   // state register; reset abandons any frame in flight without a done pulse
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // next-state: four (five with weighting) cycles per channel, then emit and wait for the sink
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     if (start) w_next = S_DLY_RD;
         S_DLY_RD:   w_next = S_DLY_WAIT;
         S_DLY_WAIT: w_next = S_SMP_RD;
`ifdef DAS_APOD_EN
         S_SMP_RD:   w_next = S_MUL;
         S_MUL:      w_next = S_ACC;
`else
         S_SMP_RD:   w_next = S_ACC;
`endif
         S_ACC:      w_next = w_last_ch ? S_EMIT : S_DLY_RD;
         S_EMIT:     if (bus.out_ready) w_next = w_last_k ? S_DONE : S_DLY_RD;
         S_DONE:     w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   // channel/output counters and the captured delay-table entry
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ch    <= '0;
         r_k     <= '0;
         r_entry <= '0;
      end else begin
         if (r_state == S_DLY_WAIT)           r_entry <= bus.dly_rd_data;
         if ((r_state == S_ACC) && !w_last_ch) r_ch   <= r_ch + 1'b1;
         if (w_accept) begin
            r_ch <= '0;
            r_k  <= w_last_k ? '0 : r_k + 1'b1;
         end
      end
   end

   // RAM address buses only move together with their read strobe
   always_ff @(posedge clk) begin
      if (reset) begin
         r_dly_addr_q <= '0;
         r_smp_addr_q <= '0;
      end else begin
         if (w_dly_en) r_dly_addr_q <= w_dly_addr;
         if (w_smp_en) r_smp_addr_q <= r_entry;
      end
   end

   // outputs decoded from state
   always_comb begin
      busy            = (r_state != S_IDLE);
      done            = (r_state == S_DONE);
      bus.dly_rd_en   = w_dly_en;
      bus.dly_rd_addr = w_dly_en ? w_dly_addr : r_dly_addr_q;
      bus.smp_rd_en   = w_smp_en;
      bus.smp_rd_addr = w_smp_en ? r_entry : r_smp_addr_q;
      bus.out_valid   = (r_state == S_EMIT);
      bus.out_data    = w_acc;
      bus.out_idx     = r_k;
   end

`ifdef DAS_APOD_EN
   logic signed [15:0] w_weight;
   assign w_weight = $signed(apod_w[r_ch*16 +: 16]);
`else
   logic w_unused_apod;
   assign w_unused_apod = ^apod_w;
`endif

   das_channel_mac #(
      .SAMPLE_W (SAMPLE_W),
      .SUM_W    (SUM_W)
   ) u_mac (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (w_clear),
      .i_acc_en (r_state == S_ACC),
      .i_use    (w_entry_ok),
      .i_sample (bus.smp_rd_data),
`ifdef DAS_APOD_EN
      .i_mul_en (r_state == S_MUL),
      .i_weight (w_weight),
`endif
      .o_acc    (w_acc)
   );
endmodule

// File: tb/tb_das_beam_sum.sv
// tb/tb_das_beam_sum.sv - self-checking bench for das_beam_sum (2-channel table/corner cases, 8-channel random)
module tb_das_beam_sum;
   localparam int SW     = 32;
   localparam int AW     = 13;
   localparam int DW     = 13;
   localparam int CH_A   = 2;
   localparam int NO_A   = 2;
   localparam int SUMW_A = 33;
   localparam int CH_B   = 8;
   localparam int NO_B   = 3;
   localparam int SUMW_B = 35;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic reset_a, start_a, busy_a, done_a;
   logic reset_b, start_b, busy_b, done_b;
   logic [CH_A*16-1:0] apod_a = '0;
   logic [CH_B*16-1:0] apod_b = '0;

   das_beam_sum_if #(.SAMPLE_W(SW), .ADDR_W(AW), .DLY_AW(DW), .SUM_W(SUMW_A)) bus_a ();
   das_beam_sum_if #(.SAMPLE_W(SW), .ADDR_W(AW), .DLY_AW(DW), .SUM_W(SUMW_B)) bus_b ();

   das_beam_sum #(.NUM_CH(CH_A), .SAMPLE_W(SW), .NUM_OUT(NO_A), .ADDR_W(AW), .DLY_AW(DW)) dut_a (
      .clk(clk), .reset(reset_a), .start(start_a), .busy(busy_a), .done(done_a), .apod_w(apod_a), .bus(bus_a));
   das_beam_sum #(.NUM_CH(CH_B), .SAMPLE_W(SW), .NUM_OUT(NO_B), .ADDR_W(AW), .DLY_AW(DW)) dut_b (
      .clk(clk), .reset(reset_b), .start(start_b), .busy(busy_b), .done(done_b), .apod_w(apod_b), .bus(bus_b));

   logic [AW-1:0] dly_mem_a [0:(1<<DW)-1];
   logic [SW-1:0] smp_mem_a [0:(1<<AW)-1];
   logic [AW-1:0] dly_mem_b [0:(1<<DW)-1];
   logic [SW-1:0] smp_mem_b [0:(1<<AW)-1];

   // one-cycle-latency RAM models
   always @(posedge clk) begin
      if (bus_a.dly_rd_en) bus_a.dly_rd_data <= dly_mem_a[bus_a.dly_rd_addr];
      if (bus_a.smp_rd_en) bus_a.smp_rd_data <= smp_mem_a[bus_a.smp_rd_addr];
      if (bus_b.dly_rd_en) bus_b.dly_rd_data <= dly_mem_b[bus_b.dly_rd_addr];
      if (bus_b.smp_rd_en) bus_b.smp_rd_data <= smp_mem_b[bus_b.smp_rd_addr];
   end

   int dly_cnt_a, smp_cnt_a, bad_smp_a;
   always @(posedge clk) begin
      if (bus_a.dly_rd_en) dly_cnt_a++;
      if (bus_a.smp_rd_en) smp_cnt_a++;
      if (bus_a.smp_rd_en && (bus_a.smp_rd_addr == {AW{1'b1}})) bad_smp_a++;
   end

   typedef struct packed {
      logic [3:0][AW-1:0] dly;
      logic [3:0][SW-1:0] smp;
      logic signed [63:0] e0;
      logic signed [63:0] e1;
   } vec_t;
   vec_t vecs [5];

   longint got_d_a [$];
   int     got_i_a [$];
   longint got_d_b [$];
   int     got_i_b [$];
   int     done_cnt_a, done_cnt_b;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint model_b(int k);
      longint s = 0;
      for (int c = 0; c < CH_B; c++)
         if (dly_mem_b[c*NO_B+k] != {AW{1'b1}})
            s += longint'($signed(smp_mem_b[dly_mem_b[c*NO_B+k]]));
      return s;
   endfunction

   task automatic load_a(input int v);
      for (int j = 0; j < 4; j++) begin
         dly_mem_a[j] = vecs[v].dly[j];
         smp_mem_a[j] = vecs[v].smp[j];
      end
   endtask

   task automatic frame_a(input bit rnd);
      int tail = -1;
      got_d_a.delete(); got_i_a.delete();
      done_cnt_a = 0; dly_cnt_a = 0; smp_cnt_a = 0; bad_smp_a = 0;
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      for (int cyc = 0; cyc < 1000 && tail != 0; cyc++) begin
         ready_set_a(rnd);
         if (bus_a.out_valid && bus_a.out_ready) begin
            got_d_a.push_back(longint'(bus_a.out_data));
            got_i_a.push_back(int'(bus_a.out_idx));
         end
         if (done_a) begin done_cnt_a++; if (tail < 0) tail = 4; end
         if (tail > 0) tail--;
         @(negedge clk);
      end
      bus_a.out_ready = 1'b1;
      chk("frame_a_done_seen", longint'(tail == 0), 1);
   endtask

   task automatic ready_set_a(input bit rnd);
      bus_a.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic frame_b(input bit rnd);
      int tail = -1;
      got_d_b.delete(); got_i_b.delete(); done_cnt_b = 0;
      @(negedge clk); start_b = 1'b1;
      @(negedge clk); start_b = 1'b0;
      for (int cyc = 0; cyc < 3000 && tail != 0; cyc++) begin
         bus_b.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus_b.out_valid && bus_b.out_ready) begin
            got_d_b.push_back(longint'(bus_b.out_data));
            got_i_b.push_back(int'(bus_b.out_idx));
         end
         if (done_b) begin done_cnt_b++; if (tail < 0) tail = 4; end
         if (tail > 0) tail--;
         @(negedge clk);
      end
      chk("frame_b_done_seen", longint'(tail == 0), 1);
   endtask

   initial begin
      int t0, t1, nvalid, held_ok;
      longint d0;

      // table order: delay entries at address ch*NUM_OUT+k, samples at addresses 0..3
      vecs[0] = '{dly: {13'd3, 13'd1, 13'd2, 13'd0},
                  smp: {32'd5, 32'd7, -32'sd3, 32'd10}, e0: 64'sd7, e1: 64'sd12};
      vecs[1] = '{dly: {13'd3, 13'h1FFF, 13'd2, 13'd0},
                  smp: {32'd5, 32'd7, -32'sd3, 32'd10}, e0: 64'sd10, e1: 64'sd12};
      vecs[2] = '{dly: {13'd3, 13'd2, 13'd1, 13'd0},
                  smp: {4{32'h7FFF_FFFF}}, e0: 64'sd4294967294, e1: 64'sd4294967294};
      vecs[3] = '{dly: {13'd3, 13'd2, 13'd1, 13'd0},
                  smp: {4{32'h8000_0000}}, e0: -64'sd4294967296, e1: -64'sd4294967296};
      vecs[4] = '{dly: {13'h1FFF, 13'd1, 13'h1FFF, 13'd0},
                  smp: {32'd5, 32'd7, -32'sd3, 32'd10}, e0: 64'sd7, e1: 64'sd0};
      smp_mem_a[(1<<AW)-1] = 32'hDEAD_BEEF;
      smp_mem_b[(1<<AW)-1] = 32'hDEAD_BEEF;

      reset_a = 1'b1; start_a = 1'b0; bus_a.out_ready = 1'b1;
      reset_b = 1'b1; start_b = 1'b0; bus_b.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      reset_a = 1'b0; reset_b = 1'b0;

      chk("rst_busy",      longint'(busy_a), 0);
      chk("rst_done",      longint'(done_a), 0);
      chk("rst_out_valid", longint'(bus_a.out_valid), 0);
      chk("rst_strobes",   longint'({bus_a.dly_rd_en, bus_a.smp_rd_en}), 0);
      chk("rst_out_data",  longint'(bus_a.out_data), 0);
      chk("rst_out_idx",   longint'(bus_a.out_idx), 0);

      for (int v = 0; v < 5; v++) begin
         load_a(v);
         nvalid = 0;
         for (int j = 0; j < 4; j++) if (vecs[v].dly[j] != {AW{1'b1}}) nvalid++;
         frame_a(v[0]);
         chk($sformatf("v%0d_count", v), got_d_a.size(), 2);
         chk($sformatf("v%0d_k0_data", v), got_d_a[0], vecs[v].e0);
         chk($sformatf("v%0d_k0_idx", v), got_i_a[0], 0);
         chk($sformatf("v%0d_k1_data", v), got_d_a[1], vecs[v].e1);
         chk($sformatf("v%0d_k1_idx", v), got_i_a[1], 1);
         chk($sformatf("v%0d_done_pulses", v), done_cnt_a, 1);
         chk($sformatf("v%0d_smp_reads", v), smp_cnt_a, nvalid);
         chk($sformatf("v%0d_invalid_reads", v), bad_smp_a, 0);
         chk($sformatf("v%0d_dly_reads", v), dly_cnt_a, 4);
      end

      // latency to first out_valid, then 10 stalled cycles at k0 with a stray start
      load_a(0);
      bus_a.out_ready = 1'b0;
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      t0 = -1; t1 = -1;
      for (int c = 0; c < 100 && t1 < 0; c++) begin
         if (bus_a.dly_rd_en && t0 < 0) t0 = c;
         if (bus_a.out_valid) t1 = c; else @(negedge clk);
      end
      chk("latency_first_valid", t1 - t0, 4 * CH_A);
      d0 = longint'(bus_a.out_data);
      chk("stall_k0_data", d0, 7);
      dly_cnt_a = 0; smp_cnt_a = 0; held_ok = 1;
      for (int c = 0; c < 10; c++) begin
         start_a = (c == 3);
         @(negedge clk);
         if (!bus_a.out_valid || longint'(bus_a.out_data) != d0 || bus_a.out_idx != 0) held_ok = 0;
      end
      start_a = 1'b0;
      chk("stall_output_held", held_ok, 1);
      chk("stall_no_reads", dly_cnt_a + smp_cnt_a, 0);
      chk("stall_busy", longint'(busy_a), 1);
      bus_a.out_ready = 1'b1;
      done_cnt_a = 0; got_d_a.delete();
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus_a.out_valid) got_d_a.push_back(longint'(bus_a.out_data));
         if (done_a) done_cnt_a++;
      end
      chk("stall_k1_data", got_d_a[0], 12);
      chk("stall_done_once", done_cnt_a, 1);
      chk("stall_idle_after", longint'(busy_a), 0);

      // reset during the k=1 accumulate cycle
      load_a(0);
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      t1 = -1;
      for (int c = 0; c < 100 && t1 < 0; c++) begin
         if (bus_a.smp_rd_en && bus_a.out_idx == 1) t1 = c;
         @(negedge clk);
      end
      chk("abort_reached_k1", longint'(t1 >= 0), 1);
      reset_a = 1'b1;
      @(negedge clk);
      reset_a = 1'b0;
      chk("abort_busy", longint'(busy_a), 0);
      chk("abort_outputs", longint'({done_a, bus_a.out_valid, bus_a.dly_rd_en, bus_a.smp_rd_en}), 0);
      chk("abort_out_data", longint'(bus_a.out_data), 0);
      chk("abort_out_idx", longint'(bus_a.out_idx), 0);
      chk("abort_addrs", longint'({bus_a.dly_rd_addr, bus_a.smp_rd_addr}), 0);
      done_cnt_a = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done_a || busy_a) done_cnt_a++;
      end
      chk("abort_no_done", done_cnt_a, 0);
      frame_a(1'b0);
      chk("restart_idx0", got_i_a[0], 0);
      chk("restart_k0_data", got_d_a[0], 7);

      // start coincident with reset is dropped
      @(negedge clk); reset_a = 1'b1; start_a = 1'b1;
      @(negedge clk); reset_a = 1'b0; start_a = 1'b0;
      @(negedge clk);
      chk("start_with_reset", longint'(busy_a), 0);

      // 8-channel extremes
      for (int e = 0; e < CH_B*NO_B; e++) begin
         dly_mem_b[e] = 13'(e);
         smp_mem_b[e] = 32'h7FFF_FFFF;
      end
      frame_b(1'b0);
      chk("b_max_k0", got_d_b[0], 64'sh3_FFFF_FFF8);
      chk("b_max_k2", got_d_b[2], 64'sh3_FFFF_FFF8);
      for (int e = 0; e < CH_B*NO_B; e++) smp_mem_b[e] = 32'h8000_0000;
      frame_b(1'b1);
      chk("b_min_k1", got_d_b[1], -64'sd17179869184);

      // 8-channel random frames against the sum-of-delayed-samples model
      for (int f = 0; f < 5; f++) begin
         for (int e = 0; e < CH_B*NO_B; e++)
            dly_mem_b[e] = ($urandom_range(0, 7) == 0) ? {AW{1'b1}} : 13'($urandom_range(0, 255));
         for (int a = 0; a < 256; a++) smp_mem_b[a] = $urandom;
         frame_b(1'b1);
         chk($sformatf("rnd%0d_count", f), got_d_b.size(), NO_B);
         chk($sformatf("rnd%0d_done", f), done_cnt_b, 1);
         for (int k = 0; k < NO_B; k++) begin
            chk($sformatf("rnd%0d_k%0d_data", f, k), got_d_b[k], model_b(k));
            chk($sformatf("rnd%0d_k%0d_idx", f, k), got_i_b[k], k);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
